icache_dm: RTL and testbench
============================

# icache_dm

Direct-mapped, read-only instruction cache between the core's instruction-fetch port (`rom_ce` / `rom_addr` / `rom_data`) and a slower word-wide instruction memory with a req/ack handshake. Hits return the instruction combinationally in the same cycle, matching the existing zero-wait ROM timing. On a miss the cache raises `stallreq`, which the stall controller treats as a third stall source (`stallreq_if`, freezing PC and IF/ID). It then refills the whole line word by word and resumes.

## Interface
Parameters:
- `LINES`, 16: number of lines; power of two, ≥2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `ce`  in  1: fetch enable from PC (`rom_ce`).
- `addr`  in  32: fetch byte address (`rom_addr`); bits [1:0] ignored.
- `data_o`  out  32: instruction to IF/ID (`rom_data`).
- `stallreq`  out  1: miss in progress; pipeline must hold PC/IF.
- `flush`  in  1: invalidate all lines, single-cycle pulse.
- `mem_req`  out  1: word read request to instruction memory.
- `mem_addr`  out  32: word-aligned request address.
- `mem_ack`  in  1: request accepted; `mem_rdata` valid this cycle.
- `mem_rdata`  in  32: returned word.

## Operation
- Address split: `off` = addr[2+OB-1:2], `idx` = next IB bits, `tag` = addr[31:2+OB+IB]. OB = log2(LINE_WORDS), IB = log2(LINES).
- Storage: `valid[LINES]`, `tag[LINES]`, data array `LINES*LINE_WORDS` words. All are registers, read combinationally.
- Hit = `ce` & `valid[idx]` & tag match & state IDLE. On a hit, `data_o` = stored word.
- `data_o` = 0 whenever `ce`=0, on a miss, or when not in IDLE.
- FSM states: IDLE, REFILL, COMMIT.
  - IDLE → REFILL when `ce` & miss & !`rst`. On this transition, latch the line base (`addr` with off and [1:0] zeroed) and clear word counter `cnt` to 0.
  - In REFILL, `mem_req`=1 and `mem_addr` = base + 4·cnt. On `mem_ack`, write `mem_rdata` to data[idx][cnt] and increment `cnt`.
  - REFILL → COMMIT on the ack where `cnt` = LINE_WORDS-1.
  - COMMIT: write the tag. Set `valid[idx]`=1 unless a flush was seen during this refill (sticky `flushed` bit). Then → IDLE.
- `stallreq` = (IDLE & `ce` & miss) | REFILL | COMMIT.
- `flush`: clears every `valid` bit at the next edge and sets `flushed` if a refill is in progress. The refill still runs to completion, but its line stays invalid, so IDLE misses again and refetches.
- Flush in IDLE on a hit cycle: the current cycle still hits; the next cycle misses.
- `addr` must be held stable while `stallreq`=1. The cache uses only the latched base/idx during refill and does not check for changes.
- `mem_addr` = 0 when `mem_req`=0. A `mem_ack` without `mem_req` is ignored.

## Timing
- Reset (sync): state IDLE, `valid` all 0, `cnt` 0, `flushed` 0, `mem_req` 0, `mem_addr` 0. While `rst`=1, `stallreq`=0 and `data_o`=0.
- Reset asserted mid-refill aborts the refill. The partially written line stays invalid.
- Hit latency: 0 cycles (combinational, same cycle as `addr`).
- Miss with a memory that acks every cycle:
  - cycle 0: detect, `stallreq`=1.
  - cycles 1..LINE_WORDS: REFILL, one word per cycle.
  - cycle LINE_WORDS+1: COMMIT.
  - cycle LINE_WORDS+2: IDLE hit, `stallreq`=0.
  - Total stall = LINE_WORDS+2 cycles (6 at default).
- Handshake: `mem_req` and `mem_addr` stay stable until the edge on which `mem_ack`=1. `mem_req` may stay high across consecutive words while `mem_addr` advances. Wait states extend REFILL one cycle per non-ack cycle.
- Simultaneous `flush` and COMMIT: the flush wins and the line is left invalid.

## Test plan
- Cold miss: reset, `ce`=1, `addr`=0x00000000, memory acks every cycle returning 0x1000+word# → `stallreq` high exactly 6 cycles; `mem_addr` sequence 0x0,0x4,0x8,0xC; then `data_o`=0x1000.
- Line hits: after the cold miss, `addr`=0x4,0x8,0xC in successive cycles → `data_o`=0x1001,0x1002,0x1003, `stallreq`=0, `mem_req`=0.
- Conflict eviction: fill 0x000, then fetch 0x100 (same idx, different tag at default params) → miss, refill from 0x100. Re-fetching 0x000 → misses again.
- Wait states: miss at 0x40 with `mem_ack` high only every 3rd cycle → each word's `mem_addr` is held until its ack; `stallreq` high 2+3·4=14 cycles; correct data afterward.
- Flush mid-refill: pulse `flush` while `cnt`=2 → refill completes, line left invalid, immediate second refill of the same line; after it, `data_o` correct.
- Reset mid-refill: assert `rst` at `cnt`=1 → next cycle `mem_req`=0, `stallreq`=0. Fetching the same address after reset → full miss.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hits and whole-line refill
// over a word-wide req/ack memory port, with a stall request toward the pipeline.
module icache_dm #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] data_o,
  output logic        stallreq,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int LA = 30 - OB;   // line-address width
  localparam int TW = LA - IB;   // tag width

  typedef enum logic [1:0] {IDLE, REFILL, COMMIT} state_t;

  state_t           state;
  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags      [LINES];
  logic [31:0]      lines_mem [LINES*LINE_WORDS];
  logic [LA-1:0]    base;
  logic [OB-1:0]    cnt;
  logic             flushed;

  logic [OB-1:0] off;
  logic [IB-1:0] idx;
  logic [TW-1:0] tag;
  logic [IB-1:0] base_idx;
  logic [TW-1:0] base_tag;
  logic          lookup_hit;
  logic          hit;
  logic          miss;
  logic          unused_addr_bits;

  assign off              = addr[2 +: OB];
  assign idx              = addr[2+OB +: IB];
  assign tag              = addr[31 -: TW];
  assign base_idx         = base[IB-1:0];
  assign base_tag         = base[LA-1:IB];
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    lookup_hit = valid[idx] && (tags[idx] == tag);
    hit        = !rst && ce && (state == IDLE) && lookup_hit;
    miss       = !rst && ce && (state == IDLE) && !lookup_hit;
    data_o     = hit ? lines_mem[{idx, off}] : '0;
    stallreq   = !rst && (miss || (state != IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      cnt      <= '0;
      flushed  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      base     <= '0;
    end else begin
      if (flush) begin
        valid <= '0;
        if (state != IDLE) flushed <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (miss) begin
            state    <= REFILL;
            base     <= addr[31:2+OB];
            cnt      <= '0;
            flushed  <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= {addr[31:2+OB], {(OB+2){1'b0}}};
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt <= cnt + OB'(1);
            if (cnt == OB'(LINE_WORDS - 1)) begin
              state    <= COMMIT;
              mem_req  <= 1'b0;
              mem_addr <= '0;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end
        COMMIT: begin
          // A flush in this very cycle has already cleared valid above; don't re-set it.
          if (!flush && !flushed) valid[base_idx] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; validity alone decides whether contents are used.
  always_ff @(posedge clk) begin
    if (!rst && (state == REFILL) && mem_ack)
      lines_mem[{base_idx, cnt}] <= mem_rdata;
    if (!rst && (state == COMMIT))
      tags[base_idx] <= base_tag;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus randomized fetches checked against
// a line-level reference model of the cache contents.
module tb_icache_dm;
  localparam int LINES      = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = 4 * LINE_WORDS;

  logic        clk = 1'b0;
  logic        rst, ce, flush, mem_ack;
  logic [31:0] addr, mem_rdata;
  logic [31:0] data_o, mem_addr;
  logic        stallreq, mem_req;

  always #5 clk = ~clk;

  icache_dm #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .data_o(data_o),
    .stallreq(stallreq), .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: which line base address each slot holds, if any.
  bit          model_valid [LINES];
  logic [31:0] model_line  [LINES];

  // Observations from the most recent fetch
  int          obs_stall;
  logic [31:0] obs_data;
  logic [31:0] obs_req[$];
  logic [31:0] obs_ack[$];
  int          obs_bad_data;
  int          obs_bad_idle;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LINE_BYTES - 1);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return model_valid[idx_of(a)] && (model_line[idx_of(a)] == line_of(a));
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    model_valid[idx_of(a)] = 1'b1;
    model_line[idx_of(a)]  = line_of(a);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
  endfunction

  // Presents one fetch until the cache stops stalling; memory acks every period-th
  // cycle of each word. flush_k>=0 pulses flush once while that many words are done.
  task automatic fetch(input logic [31:0] a, input int period, input int flush_k);
    int wc = 0;
    int k = 0;
    bit flushed_once = 1'b0;
    obs_stall = 0; obs_data = '0; obs_bad_data = 0; obs_bad_idle = 0;
    obs_req.delete(); obs_ack.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      rst = 1'b0; ce = 1'b1; addr = a; flush = 1'b0;
      mem_ack   = mem_req && (wc == period - 1);
      mem_rdata = mem_ack ? mem_fn(mem_addr) : $urandom;
      if (mem_req && k == flush_k && !flushed_once) begin
        flush = 1'b1;
        flushed_once = 1'b1;
      end
      #1;
      if (mem_req) obs_req.push_back(mem_addr);
      else if (mem_addr !== 32'h0) obs_bad_idle++;
      if (mem_ack) begin obs_ack.push_back(mem_addr); wc = 0; k++; end
      else if (mem_req) wc++;
      if (stallreq !== 1'b0) begin
        obs_stall++;
        if (data_o !== 32'h0) obs_bad_data++;
      end else begin
        obs_data = data_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; addr = 32'h0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({stallreq, mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ctrl: stallreq/mem_req=%b want 00", {stallreq, mem_req});
    end
    vectors++;
    if (data_o !== 32'h0 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: data_o=%h mem_addr=%h want 0/0", data_o, mem_addr);
    end
    model_clear();
  endtask

  task automatic test_cold_miss();
    bit ok;
    fetch(32'h0, 1, -1);
    vectors++;
    if (obs_stall !== LINE_WORDS + 2) begin
      miscompares++;
      $display("FAIL cold_stall: got %0d want %0d", obs_stall, LINE_WORDS + 2);
    end
    ok = (obs_ack.size() == LINE_WORDS);
    foreach (obs_ack[i]) if (obs_ack[i] !== 32'(4 * i)) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL cold_addr_seq: got %0d acks first=%h want %0d acks from 0", obs_ack.size(),
               (obs_ack.size() > 0) ? obs_ack[0] : 32'hx, LINE_WORDS);
    end
    vectors++;
    if (obs_data !== 32'h1000) begin
      miscompares++;
      $display("FAIL cold_data: got %h want %h", obs_data, 32'h1000);
    end
    vectors++;
    if (obs_bad_data != 0 || obs_bad_idle != 0) begin
      miscompares++;
      $display("FAIL cold_quiet: data_o nonzero %0d, idle mem_addr nonzero %0d, want 0/0",
               obs_bad_data, obs_bad_idle);
    end
    model_fill(32'h0);
  endtask

  task automatic test_line_hits();
    for (int k = 1; k < LINE_WORDS; k++) begin
      fetch(32'(4 * k), 1, -1);
      vectors++;
      if (obs_stall !== 0 || obs_req.size() != 0) begin
        miscompares++;
        $display("FAIL hit_stall[%0d]: stall=%0d req=%0d want 0/0", k, obs_stall, obs_req.size());
      end
      vectors++;
      if (obs_data !== 32'h1000 + 32'(k)) begin
        miscompares++;
        $display("FAIL hit_data[%0d]: got %h want %h", k, obs_data, 32'h1000 + 32'(k));
      end
    end
  endtask

  task automatic test_conflict();
    fetch(32'h100, 1, -1);
    vectors++;
    if (obs_stall !== LINE_WORDS + 2 || obs_ack.size() == 0 || obs_ack[0] !== 32'h100) begin
      miscompares++;
      $display("FAIL conflict_miss: stall=%0d first_ack=%h want %0d/100", obs_stall,
               (obs_ack.size() > 0) ? obs_ack[0] : 32'hx, LINE_WORDS + 2);
    end
    vectors++;
    if (obs_data !== mem_fn(32'h100)) begin
      miscompares++;
      $display("FAIL conflict_data: got %h want %h", obs_data, mem_fn(32'h100));
    end
    model_fill(32'h100);
    fetch(32'h0, 1, -1);
    vectors++;
    if (obs_stall !== LINE_WORDS + 2 || obs_data !== 32'h1000) begin
      miscompares++;
      $display("FAIL conflict_refetch: stall=%0d data=%h want %0d/1000", obs_stall, obs_data,
               LINE_WORDS + 2);
    end
    model_fill(32'h0);
  endtask

  task automatic test_wait_states();
    bit ok;
    fetch(32'h40, 3, -1);
    vectors++;
    if (obs_stall !== 2 + 3 * LINE_WORDS) begin
      miscompares++;
      $display("FAIL wait_stall: got %0d want %0d", obs_stall, 2 + 3 * LINE_WORDS);
    end
    ok = (obs_req.size() == 3 * LINE_WORDS);
    foreach (obs_req[i]) if (obs_req[i] !== 32'h40 + 32'(4 * (i / 3))) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_addr_hold: got %0d req cycles want %0d, each addr held 3 cycles",
               obs_req.size(), 3 * LINE_WORDS);
    end
    vectors++;
    if (obs_data !== mem_fn(32'h40)) begin
      miscompares++;
      $display("FAIL wait_data: got %h want %h", obs_data, mem_fn(32'h40));
    end
    model_fill(32'h40);
  endtask

  task automatic test_flush_mid_refill();
    bit ok;
    fetch(32'h80, 1, 2);
    vectors++;
    if (obs_stall !== 2 * (LINE_WORDS + 2)) begin
      miscompares++;
      $display("FAIL flush_stall: got %0d want %0d", obs_stall, 2 * (LINE_WORDS + 2));
    end
    ok = (obs_ack.size() == 2 * LINE_WORDS);
    foreach (obs_ack[i]) if (obs_ack[i] !== 32'h80 + 32'(4 * (i % LINE_WORDS))) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL flush_refetch_seq: got %0d acks want %0d (line 80 twice)", obs_ack.size(),
               2 * LINE_WORDS);
    end
    vectors++;
    if (obs_data !== mem_fn(32'h80)) begin
      miscompares++;
      $display("FAIL flush_data: got %h want %h", obs_data, mem_fn(32'h80));
    end
    model_clear();
    model_fill(32'h80);
    fetch(32'h0, 1, -1);
    vectors++;
    if (obs_stall !== LINE_WORDS + 2) begin
      miscompares++;
      $display("FAIL flush_invalidated: stall=%0d want %0d", obs_stall, LINE_WORDS + 2);
    end
    model_fill(32'h0);
  endtask

  task automatic test_flush_hit();
    @(negedge clk);
    rst = 1'b0; ce = 1'b1; addr = 32'h84; flush = 1'b1; mem_ack = 1'b0;
    #1;
    vectors++;
    if (stallreq !== 1'b0 || data_o !== mem_fn(32'h84)) begin
      miscompares++;
      $display("FAIL flush_hit_same: stall=%b data=%h want 0/%h", stallreq, data_o, mem_fn(32'h84));
    end
    model_clear();
    fetch(32'h84, 1, -1);
    vectors++;
    if (obs_stall !== LINE_WORDS + 2 || obs_data !== mem_fn(32'h84)) begin
      miscompares++;
      $display("FAIL flush_hit_next: stall=%0d data=%h want %0d/%h", obs_stall, obs_data,
               LINE_WORDS + 2, mem_fn(32'h84));
    end
    model_fill(32'h84);
  endtask

  task automatic test_reset_mid_refill();
    int acks = 0;
    bit reached = 1'b0;
    @(negedge clk);
    rst = 1'b0; ce = 1'b1; addr = 32'hC0; flush = 1'b0; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (mem_req && acks == 1) begin
        rst = 1'b1; mem_ack = 1'b0; reached = 1'b1;
        break;
      end
      mem_ack = mem_req;
      mem_rdata = mem_fn(mem_addr);
      #1;
      if (mem_ack) acks++;
    end
    #1;
    vectors++;
    if (!reached || stallreq !== 1'b0 || data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_during: reached=%b stall=%b data=%h want 1/0/0", reached, stallreq, data_o);
    end
    @(negedge clk);
    rst = 1'b0; ce = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || stallreq !== 1'b0 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_after: mem_req=%b stall=%b mem_addr=%h want 0/0/0", mem_req, stallreq,
               mem_addr);
    end
    model_clear();
    fetch(32'hC0, 1, -1);
    vectors++;
    if (obs_stall !== LINE_WORDS + 2 || obs_data !== mem_fn(32'hC0)) begin
      miscompares++;
      $display("FAIL rst_mid_refetch: stall=%0d data=%h want %0d/%h", obs_stall, obs_data,
               LINE_WORDS + 2, mem_fn(32'hC0));
    end
    model_fill(32'hC0);
  endtask

  task automatic test_random();
    logic [31:0] tag_pool [4];
    logic [31:0] a;
    int          p;
    bit          exp_hit;
    tag_pool[0] = 32'h0; tag_pool[1] = 32'h1; tag_pool[2] = 32'hABCDE; tag_pool[3] = 32'hFFFFFF;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        rst = 1'b0; ce = 1'b0; flush = 1'b1; mem_ack = 1'b0;
        model_clear();
      end
      a = (tag_pool[$urandom_range(0, 3)] * 32'(LINE_BYTES * LINES))
        + 32'($urandom_range(0, 3) * LINE_BYTES)
        + 32'($urandom_range(0, LINE_WORDS - 1) * 4) + 32'($urandom_range(0, 3));
      p = $urandom_range(1, 3);
      exp_hit = model_hit(a);
      fetch(a, p, -1);
      vectors++;
      if (obs_stall !== (exp_hit ? 0 : 2 + p * LINE_WORDS)) begin
        miscompares++;
        $display("FAIL rand_stall[%0d] a=%h: got %0d want %0d", n, a, obs_stall,
                 exp_hit ? 0 : 2 + p * LINE_WORDS);
      end
      vectors++;
      if (obs_data !== mem_fn(a & ~32'h3)) begin
        miscompares++;
        $display("FAIL rand_data[%0d] a=%h: got %h want %h", n, a, obs_data, mem_fn(a & ~32'h3));
      end
      vectors++;
      if (obs_ack.size() != (exp_hit ? 0 : LINE_WORDS) ||
          (!exp_hit && obs_ack[0] !== line_of(a))) begin
        miscompares++;
        $display("FAIL rand_refill[%0d] a=%h: got %0d acks want %0d from %h", n, a, obs_ack.size(),
                 exp_hit ? 0 : LINE_WORDS, line_of(a));
      end
      model_fill(a);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_conflict();
    test_wait_states();
    test_flush_mid_refill();
    test_flush_hit();
    test_reset_mid_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
